// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-memory bus of the load/store unit
// Core side: req_valid/req_ready handshake, req_we/req_size/req_unsigned/req_addr/req_wdata fields,
//   resp_valid pulse with resp_err/resp_rdata.
// Memory side: mem_addr word index, mem_wd write word, mem_we write enable, mem_rd combinational read word.
// slave = the unit; master = the core plus memory around it.
interface load_store_unit_if;
  logic req_valid, req_ready, req_we, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic mem_we;
  modport master(
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wd, mem_we
  );
  modport slave(
    input req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word loads and stores onto a word-wide data memory
// Ports: clk, rst_n (async active-low), bus (load_store_unit_if.slave).
// Sub-word stores use read-modify-write (READ then WRITE); misaligned, illegal-size and
// out-of-range requests go straight to RESP with resp_err and never touch memory.
// Every output is decoded from registered state only, so none has a path from the inputs.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input logic clk,
  input logic rst_n,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state;
  logic we, uns, err, req_err;
  logic [1:0] size;
  logic [31:0] addr, wdata, buf_q, ext, merged;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    req_err = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
              (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
              {2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS);
    b = buf_q[8*addr[1:0] +: 8];
    h = addr[1] ? buf_q[31:16] : buf_q[15:0];
    ext = size == 2'b00 ? {{24{b[7] & ~uns}}, b} :
          size == 2'b01 ? {{16{h[15] & ~uns}}, h} : buf_q;
    merged = buf_q;
    if (size == 2'b00) merged[8*addr[1:0] +: 8] = wdata[7:0];
    else merged[16*addr[1] +: 16] = wdata[15:0];
  end
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_err = state == RESP && err;
  assign bus.resp_rdata = (state == RESP && !we && !err) ? ext : 32'd0;
  assign bus.mem_we = state == WRITE;
  assign bus.mem_addr = (state == READ || state == WRITE) ? {2'b00, addr[31:2]} : 32'd0;
  assign bus.mem_wd = state == WRITE ? (size == 2'b10 ? wdata : merged) : 32'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      buf_q <= '0;
      we <= 1'b0;
      uns <= 1'b0;
      err <= 1'b0;
      size <= '0;
      addr <= '0;
      wdata <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          we <= bus.req_we;
          uns <= bus.req_unsigned;
          size <= bus.req_size;
          addr <= bus.req_addr;
          wdata <= bus.req_wdata;
          err <= req_err;
          state <= req_err ? RESP : (bus.req_we && bus.req_size == 2'b10) ? WRITE : READ;
        end
        READ: begin
          buf_q <= bus.mem_rd;
          state <= we ? WRITE : RESP;
        end
        WRITE: state <= RESP;
        default: state <= IDLE;
      endcase
    end
endmodule
